tug_referee: RTL and testbench
==============================

TUG_REFEREE -- requirements
Module: tug_referee

Interface
REQ-001 Parameter START_TICKS, default 4, slowen256 ticks of countdown before play opens (legal 1..255).
REQ-002 Parameter HOLD_TICKS, default 8, slowen256 ticks the result is held after a win (legal 1..255).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 slowen256  input  1  single-cycle slow-tick enable.
REQ-006 leftp  input  1  left-player push, debounced single-cycle pulse.
REQ-007 rightp  input  1  right-player push, debounced single-cycle pulse.
REQ-008 pos_leds  output  7  one-hot rope marker; bit 0 rightmost LED.
REQ-009 over  output  1  level, high for the whole result-hold period.
REQ-010 winright  output  1  winner side, valid while over=1 (1 = right won).
REQ-011 playing  output  1  high while pushes move the rope.
REQ-012 left_wins, right_wins  output  4 each  round-win tallies.

Function
REQ-013 All outputs SHALL be registered; the effect of an input sampled at edge n SHALL be visible after edge n.
REQ-014 States SHALL be IDLE (countdown), PLAY, OVER; no other state is reachable, and an illegal encoding SHALL go to IDLE on the next edge.
REQ-015 Rope position pos SHALL be a 4-bit register, range 0..8, centre 4; pos_leds bit (pos-1) SHALL be set for pos 1..7; pos_leds SHALL be 7'b0000000 for pos 0 or 8.
REQ-016 IDLE: tick counter SHALL count slowen256 ticks; after START_TICKS ticks the state SHALL become PLAY with counter cleared, playing=1 from the next edge.
REQ-017 IDLE, exactly one of leftp/rightp high (false start): state SHALL go to OVER with the other side as winner (rightp fouls -> winright=0); pos stays 4.
REQ-018 IDLE, leftp and rightp high together: countdown counter SHALL restart from 0; no winner.
REQ-019 PLAY, rightp only: pos SHALL decrement by 1; leftp only: pos SHALL increment by 1; both or neither: pos unchanged.
REQ-020 PLAY, push taking pos to 0: next state OVER, winright=1; to 8: OVER, winright=0; no step past 0 or 8.
REQ-021 Entering OVER SHALL set over=1, playing=0, and increment the winner tally exactly once; a tally at 15 SHALL saturate.
REQ-022 OVER: leftp/rightp SHALL be ignored; winright SHALL be stable; after HOLD_TICKS slowen256 ticks the state SHALL become IDLE, over=0, pos=4, counter cleared.
REQ-023 A slowen256 coinciding with the edge that enters a state SHALL NOT count toward that state's tick total.
REQ-024 A push and a slowen256 in the same cycle SHALL both take effect.

Reset
REQ-025 rst=1 SHALL override all other inputs at that edge: state IDLE, counter 0, pos=4 (pos_leds=7'b0001000), over=0, winright=0, playing=0, left_wins=0, right_wins=0.
REQ-026 Reset asserted mid-PLAY or mid-OVER SHALL abandon the round without updating tallies.
REQ-027 No output SHALL change without a clk edge.

Verification
REQ-028 Reset, then 4 slowen256 pulses, no pushes -> playing=1 after 4th tick edge, pos_leds=7'b0001000.
REQ-029 In PLAY, 4 rightp pulses -> pos_leds 0000100, 0000010, 0000001, then over=1, winright=1, right_wins=1, pos_leds=0000000; after 8 ticks over=0, pos_leds=0001000, playing=0.
REQ-030 In IDLE after 2 ticks, single rightp pulse -> over=1, winright=0, left_wins=1, pos_leds=0001000.
REQ-031 In PLAY, leftp and rightp same cycle x3 -> pos_leds unchanged 0001000; in IDLE simultaneous pulse -> countdown restarts, play opens 4 ticks later.
REQ-032 Drive 16 right wins -> right_wins saturates at 15; rst mid-OVER -> all outputs reset values next edge, tallies 0.
REQ-033 Pushes during OVER (both sides, every cycle) -> winright, tallies, pos_leds unchanged until return to IDLE.

Source files
------------

// File: rtl/tug_referee.sv
// Tug-of-war referee: countdown, rope play and result hold, driven by a slow
// tick enable and two debounced push pulses. All outputs are registered.
module tug_referee #(
  parameter int START_TICKS = 4,
  parameter int HOLD_TICKS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slowen256,
  input  logic       leftp,
  input  logic       rightp,
  output logic [6:0] pos_leds,
  output logic       over,
  output logic       winright,
  output logic       playing,
  output logic [3:0] left_wins,
  output logic [3:0] right_wins
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_e;

  localparam logic [3:0] POS_CENTRE = 4'd4;
  localparam logic [3:0] POS_RIGHT  = 4'd0;
  localparam logic [3:0] POS_LEFT   = 4'd8;
  localparam logic [7:0] START_LAST = 8'(START_TICKS);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_TICKS);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] pos_q, pos_d;
  logic [6:0] leds_q, leds_d;
  logic       over_q, over_d;
  logic       winright_q, winright_d;
  logic       playing_q, playing_d;
  logic [3:0] left_wins_q, left_wins_d;
  logic [3:0] right_wins_q, right_wins_d;

  logic       one_push;
  logic       win_evt;
  logic       win_is_right;

  assign one_push = leftp ^ rightp;

  // State and output registers; rst takes priority over every input.
  // NOTE: sequential state uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pos_q        <= POS_CENTRE;
      leds_q       <= 7'b0001000;
      over_q       <= 1'b0;
      winright_q   <= 1'b0;
      playing_q    <= 1'b0;
      left_wins_q  <= '0;
      right_wins_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      leds_q       <= leds_d;
      over_q       <= over_d;
      winright_q   <= winright_d;
      playing_q    <= playing_d;
      left_wins_q  <= left_wins_d;
      right_wins_q <= right_wins_d;
    end
  end

  // Next state, tick counter and rope position.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    unique case (state_q)
      S_IDLE: begin
        if (one_push) begin
          state_d = S_OVER;
          cnt_d   = '0;
        end else if (leftp && rightp) begin
          cnt_d = '0;
        end else if (slowen256) begin
          if (cnt_q + 8'd1 == START_LAST) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_PLAY: begin
        if (leftp && !rightp)      pos_d = pos_q + 4'd1;
        else if (rightp && !leftp) pos_d = pos_q - 4'd1;
        if (pos_d == POS_RIGHT || pos_d == POS_LEFT) begin
          state_d = S_OVER;
          cnt_d   = '0;
        end
      end
      S_OVER: begin
        if (slowen256) begin
          if (cnt_q + 8'd1 == HOLD_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pos_d   = POS_CENTRE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pos_d   = POS_CENTRE;
      end
    endcase
  end

  // Output values for the next edge, derived from the next state.
  always_comb begin
    win_evt      = (state_q == S_IDLE || state_q == S_PLAY) && (state_d == S_OVER);
    win_is_right = (state_q == S_IDLE) ? leftp : (pos_d == POS_RIGHT);
    winright_d   = win_evt ? win_is_right : winright_q;
    left_wins_d  = left_wins_q;
    right_wins_d = right_wins_q;
    if (win_evt && win_is_right && right_wins_q != 4'hF) right_wins_d = right_wins_q + 4'd1;
    if (win_evt && !win_is_right && left_wins_q != 4'hF) left_wins_d  = left_wins_q + 4'd1;
    over_d    = (state_d == S_OVER);
    playing_d = (state_d == S_PLAY);
    leds_d    = (pos_d >= 4'd1 && pos_d <= 4'd7) ? (7'd1 << (pos_d - 4'd1)) : 7'd0;
  end

  assign pos_leds   = leds_q;
  assign over       = over_q;
  assign winright   = winright_q;
  assign playing    = playing_q;
  assign left_wins  = left_wins_q;
  assign right_wins = right_wins_q;

endmodule

// File: tb/tb_tug_referee.sv
// Scoreboard bench for tug_referee: a driver applies one vector per cycle and
// queues the reference model's prediction; a monitor checks after each edge.
module tb_tug_referee;

  localparam int START_TICKS = 4;
  localparam int HOLD_TICKS  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slowen256 = 1'b0;
  logic       leftp = 1'b0;
  logic       rightp = 1'b0;
  logic [6:0] pos_leds;
  logic       over, winright, playing;
  logic [3:0] left_wins, right_wins;

  tug_referee #(.START_TICKS(START_TICKS), .HOLD_TICKS(HOLD_TICKS)) dut (
    .clk(clk), .rst(rst), .slowen256(slowen256), .leftp(leftp), .rightp(rightp),
    .pos_leds(pos_leds), .over(over), .winright(winright), .playing(playing),
    .left_wins(left_wins), .right_wins(right_wins)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] leds;
    logic       over;
    logic       winright;
    logic       playing;
    logic [3:0] lw;
    logic [3:0] rw;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: game phase as a word, rope as a plain integer.
  string m_phase = "idle";
  int    m_ticks = 0;
  int    m_rope = 4;
  bit    m_right_won = 0;
  int    m_lw = 0, m_rw = 0;

  function automatic void award(input bit right_side);
    m_phase     = "over";
    m_ticks     = 0;
    m_right_won = right_side;
    if (right_side) m_rw = (m_rw < 15) ? m_rw + 1 : 15;
    else            m_lw = (m_lw < 15) ? m_lw + 1 : 15;
  endfunction

  function automatic void model_step(input bit r, input bit t, input bit l, input bit p);
    if (r) begin
      m_phase = "idle"; m_ticks = 0; m_rope = 4; m_right_won = 0; m_lw = 0; m_rw = 0;
    end else if (m_phase == "idle") begin
      if (l != p)     award(l);        // the side that did not foul wins
      else if (l)     m_ticks = 0;
      else if (t) begin
        m_ticks++;
        if (m_ticks == START_TICKS) begin m_phase = "play"; m_ticks = 0; end
      end
    end else if (m_phase == "play") begin
      m_rope += (l && !p) ? 1 : (p && !l) ? -1 : 0;
      if (m_rope == 0)      award(1'b1);
      else if (m_rope == 8) award(1'b0);
    end else begin
      if (t) begin
        m_ticks++;
        if (m_ticks == HOLD_TICKS) begin m_phase = "idle"; m_ticks = 0; m_rope = 4; end
      end
    end
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.leds     = (m_rope >= 1 && m_rope <= 7) ? 7'(1 << (m_rope - 1)) : 7'd0;
    e.over     = (m_phase == "over");
    e.winright = m_right_won;
    e.playing  = (m_phase == "play");
    e.lw       = 4'(m_lw);
    e.rw       = 4'(m_rw);
    return e;
  endfunction

  task automatic cyc(input bit r, input bit t, input bit l, input bit p);
    @(negedge clk);
    rst = r; slowen256 = t; leftp = l; rightp = p;
    model_step(r, t, l, p);
    exp_q.push_back(predict());
  endtask

  task automatic check(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at vector %0d: got %0d, expected %0d", name, vectors, act, exp);
    end
  endtask

  // Monitor: one expectation per driven edge, sampled 1 time unit after it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      check("pos_leds",   int'(pos_leds),   int'(e.leds));
      check("over",       int'(over),       int'(e.over));
      check("winright",   int'(winright),   int'(e.winright));
      check("playing",    int'(playing),    int'(e.playing));
      check("left_wins",  int'(left_wins),  int'(e.lw));
      check("right_wins", int'(right_wins), int'(e.rw));
    end
  end

  task automatic tick_until(input string phase);
    for (int g = 0; g < 100 && m_phase != phase; g++) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic right_round();
    tick_until("play");
    for (int g = 0; g < 10 && m_phase == "play"; g++) cyc(0, 0, 0, 1);
  endtask

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);

    // Countdown with no pushes, then simultaneous pushes leave the rope put.
    for (int i = 0; i < START_TICKS; i++) begin cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); end
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1);

    // Right pulls the rope to its end, then the hold expires.
    for (int i = 0; i < 4; i++) begin cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); end
    tick_until("idle");

    // False start by right after two ticks; pushes every cycle during hold.
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
    for (int g = 0; g < 100 && m_phase == "over"; g++) cyc(0, (g % 3) == 0, 1, 1);

    // Simultaneous pushes in countdown restart it; a push with a tick counts both.
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 1, 1);
    tick_until("play");
    cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);

    // Sixteen right wins saturate the tally.
    tick_until("idle");
    for (int i = 0; i < 16; i++) begin
      right_round();
      tick_until("idle");
    end

    // Reset in the middle of a hold.
    right_round();
    cyc(0, 1, 0, 0); cyc(0, 1, 1, 1);
    cyc(1, 1, 1, 0);
    cyc(0, 0, 0, 0);

    // Random traffic with rare resets.
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    cyc(0, 0, 0, 0);

    for (int g = 0; g < 10 && exp_q.size() > 0; g++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
